// File: rtl/mario_motion_if.sv
// Bundles Mario's frame/keyboard/pixel inputs and position outputs.
//   master: drives frame_clk, keycode, DrawX, DrawY; observes the results
//   slave : the motion block; drives Is_Mario, Mario_X, Mario_Y, Mario_State
interface mario_motion_if;
    logic       frame_clk;
    logic [7:0] keycode;
    logic [9:0] DrawX;
    logic [9:0] DrawY;
    logic       Is_Mario;
    logic [9:0] Mario_X;
    logic [9:0] Mario_Y;
    logic [1:0] Mario_State;

    modport master (
        output frame_clk, keycode, DrawX, DrawY,
        input  Is_Mario, Mario_X, Mario_Y, Mario_State
    );

    modport slave (
        input  frame_clk, keycode, DrawX, DrawY,
        output Is_Mario, Mario_X, Mario_Y, Mario_State
    );
endinterface

// File: rtl/mario_motion.sv
// Per-frame Mario motion (walk, jump, gravity, clamping) and per-pixel box hit.
//   Clk   : system clock
//   Reset : synchronous, active-high
//   bus   : frame_clk/keycode/DrawX/DrawY in; Is_Mario (combinational),
//           Mario_X/Mario_Y/Mario_State (registered) out
module mario_motion #(
    parameter int unsigned X_START  = 100,
    parameter int unsigned X_MAX    = 639,
    parameter int unsigned GROUND_Y = 400,
    parameter int unsigned MARIO_W  = 16,
    parameter int unsigned MARIO_H  = 16,
    parameter int unsigned X_STEP   = 2,
    parameter int unsigned JUMP_VEL = 12,
    parameter int unsigned GRAVITY  = 1,
    parameter int unsigned MAX_FALL = 8
) (
    input  logic           Clk,
    input  logic           Reset,
    mario_motion_if.slave  bus
);

    localparam logic [7:0]         KEY_LEFT  = 8'h04;
    localparam logic [7:0]         KEY_RIGHT = 8'h07;
    localparam logic [7:0]         KEY_JUMP  = 8'h1A;
    localparam logic [9:0]         X_RESET   = 10'(X_START);
    localparam logic [9:0]         X_LIM     = 10'(X_MAX - MARIO_W + 1);
    localparam logic [9:0]         X_INC     = 10'(X_STEP);
    localparam logic [9:0]         Y_REST    = 10'(GROUND_Y - MARIO_H);
    localparam logic signed [10:0] Y_REST_S  = 11'(GROUND_Y - MARIO_H);
    localparam logic signed [7:0]  VY_JUMP   = 8'(0) - 8'(JUMP_VEL);
    localparam logic signed [7:0]  VY_GRAV   = 8'(GRAVITY);
    localparam logic signed [7:0]  VY_MAX    = 8'(MAX_FALL);
    localparam logic [10:0]        BOX_W_M1  = 11'(MARIO_W - 1);
    localparam logic [10:0]        BOX_H_M1  = 11'(MARIO_H - 1);

    typedef enum logic [1:0] {
        GROUND  = 2'b00,
        RISING  = 2'b01,
        FALLING = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [9:0]         x_q, x_d;
    logic [9:0]         y_q, y_d;
    logic signed [7:0]  vy_q, vy_d;
    logic               armed_q, armed_d;
    logic               frame_clk_d;

    logic               tick;
    logic signed [10:0] y_sum;
    logic signed [7:0]  vy_inc;

    // Rising edge of the frame strobe, one Clk wide.
    assign tick   = bus.frame_clk & ~frame_clk_d;
    // Candidate position/velocity using the current velocity; 11 bits so no wrap.
    assign y_sum  = $signed({1'b0, y_q}) + $signed({{3{vy_q[7]}}, vy_q});
    assign vy_inc = vy_q + VY_GRAV;

    // State and motion registers; Reset takes priority over a coincident tick.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q     <= GROUND;
            x_q         <= X_RESET;
            y_q         <= Y_REST;
            vy_q        <= 8'sd0;
            armed_q     <= 1'b1;
            frame_clk_d <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            y_q         <= y_d;
            vy_q        <= vy_d;
            armed_q     <= armed_d;
            frame_clk_d <= bus.frame_clk;
        end
    end

    // Next-state and per-frame motion update; everything holds between ticks.
    always_comb begin
        state_d = state_q;
        x_d     = x_q;
        y_d     = y_q;
        vy_d    = vy_q;
        armed_d = armed_q;

        if (tick) begin
            if (bus.keycode == KEY_LEFT) begin
                x_d = (x_q < X_INC) ? 10'd0 : x_q - X_INC;
            end else if (bus.keycode == KEY_RIGHT) begin
                x_d = (x_q >= X_LIM - X_INC) ? X_LIM : x_q + X_INC;
            end

            // Any non-jump frame re-arms, so a held W cannot bounce repeatedly.
            if (bus.keycode != KEY_JUMP) begin
                armed_d = 1'b1;
            end

            case (state_q)
                GROUND: begin
                    if (bus.keycode == KEY_JUMP && armed_q) begin
                        vy_d    = VY_JUMP;
                        armed_d = 1'b0;
                        state_d = RISING;
                    end else begin
                        vy_d = 8'sd0;
                    end
                end
                RISING: begin
                    if (y_sum < 11'sd0) begin
                        // Head bump at the top of the screen.
                        y_d     = 10'd0;
                        vy_d    = 8'sd0;
                        state_d = FALLING;
                    end else begin
                        y_d  = 10'(y_sum);
                        vy_d = vy_inc;
                        if (vy_inc >= 8'sd0) begin
                            state_d = FALLING;
                        end
                    end
                end
                FALLING: begin
                    if (y_sum >= Y_REST_S) begin
                        // Snap onto the ground; never below the rest row.
                        y_d     = Y_REST;
                        vy_d    = 8'sd0;
                        state_d = GROUND;
                    end else begin
                        y_d  = 10'(y_sum);
                        vy_d = (vy_inc > VY_MAX) ? VY_MAX : vy_inc;
                    end
                end
                default: begin
                    state_d = GROUND;
                    y_d     = Y_REST;
                    vy_d    = 8'sd0;
                end
            endcase
        end
    end

    // Zero-latency box hit against the registered position.
    always_comb begin
        bus.Is_Mario = ({1'b0, bus.DrawX} >= {1'b0, x_q}) &&
                       ({1'b0, bus.DrawX} <= {1'b0, x_q} + BOX_W_M1) &&
                       ({1'b0, bus.DrawY} >= {1'b0, y_q}) &&
                       ({1'b0, bus.DrawY} <= {1'b0, y_q} + BOX_H_M1);
    end

    assign bus.Mario_X     = x_q;
    assign bus.Mario_Y     = y_q;
    assign bus.Mario_State = state_q;

endmodule

// File: tb/tb_mario_motion.sv
// Directed bench for mario_motion: vector table plus multi-cycle corner cases.
module tb_mario_motion;

    logic clk;
    logic reset;
    int   checks;
    int   errors;
    logic mon_en;

    mario_motion_if bus();

    mario_motion dut (
        .Clk   (clk),
        .Reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] kc;
        int         n;
        int         x;
        int         y;
        int         st;
        int         vy;
    } vec_t;

    vec_t tbl [12];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_ticks(input logic [7:0] kc, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            bus.keycode   = kc;
            bus.frame_clk = 1'b1;
            @(negedge clk);
            bus.frame_clk = 1'b0;
        end
    endtask

    task automatic check_pos(input string tag, input int x, input int y, input int st, input int vy);
        check({tag, " X"},     int'(bus.Mario_X), x);
        check({tag, " Y"},     int'(bus.Mario_Y), y);
        check({tag, " state"}, int'(bus.Mario_State), st);
        check({tag, " vy"},    int'($signed(dut.vy_q)), vy);
    endtask

    task automatic check_hit(input int dx, input int dy, input int exp);
        bus.DrawX = 10'(dx);
        bus.DrawY = 10'(dy);
        #1;
        check($sformatf("hit(%0d,%0d)", dx, dy), int'(bus.Is_Mario), exp);
    endtask

    // Position must never leave the legal range at any point in the run.
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            checks++;
            if (bus.Mario_Y > 10'd384 || bus.Mario_X > 10'd624) begin
                errors++;
                $display("FAIL range: got X=%0d Y=%0d limit X<=624 Y<=384", bus.Mario_X, bus.Mario_Y);
            end
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        mon_en        = 1'b0;
        reset         = 1'b1;
        bus.frame_clk = 1'b0;
        bus.keycode   = 8'h00;
        bus.DrawX     = 10'd0;
        bus.DrawY     = 10'd0;

        tbl[0]  = '{8'h00,   3, 100, 384, 0,   0};
        tbl[1]  = '{8'h07,  10, 120, 384, 0,   0};
        tbl[2]  = '{8'h07, 300, 624, 384, 0,   0};
        tbl[3]  = '{8'h04, 310,   4, 384, 0,   0};
        tbl[4]  = '{8'h04,   1,   2, 384, 0,   0};
        tbl[5]  = '{8'h04,   1,   0, 384, 0,   0};
        tbl[6]  = '{8'h04,   3,   0, 384, 0,   0};
        tbl[7]  = '{8'h1A,   1,   0, 384, 1, -12};
        tbl[8]  = '{8'h00,  12,   0, 306, 2,   0};
        tbl[9]  = '{8'h00,  14,   0, 382, 2,   8};
        tbl[10] = '{8'h00,   1,   0, 384, 0,   0};
        tbl[11] = '{8'h00,   2,   0, 384, 0,   0};

        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        mon_en = 1'b1;

        check_pos("reset", 100, 384, 0, 0);
        check_hit(100, 384, 1);
        check_hit(115, 399, 1);
        check_hit(116, 384, 0);
        check_hit(100, 383, 0);
        check_hit(99, 390, 0);
        check_hit(110, 400, 0);

        for (int i = 0; i < 12; i++) begin
            do_ticks(tbl[i].kc, tbl[i].n);
            check_pos($sformatf("vec%0d", i), tbl[i].x, tbl[i].y, tbl[i].st, tbl[i].vy);
        end

        // Holding W through a whole jump lands and stays grounded.
        do_ticks(8'h1A, 28);
        check_pos("holdW land", 0, 384, 0, 0);
        do_ticks(8'h1A, 5);
        check_pos("holdW no rejump", 0, 384, 0, 0);
        do_ticks(8'h00, 1);
        do_ticks(8'h1A, 1);
        check_pos("rearm jump", 0, 384, 1, -12);
        do_ticks(8'h00, 4);
        check_pos("mid rise", 0, 342, 1, -8);

        // Reset mid-rise with a coincident tick and a walk key.
        @(negedge clk);
        reset         = 1'b1;
        bus.keycode   = 8'h07;
        bus.frame_clk = 1'b1;
        @(negedge clk);
        check_pos("reset mid-rise", 100, 384, 0, 0);
        reset         = 1'b0;
        bus.frame_clk = 1'b0;
        repeat (2) @(negedge clk);
        check_pos("post reset hold", 100, 384, 0, 0);

        // A strobe held high gives exactly one step.
        bus.keycode   = 8'h07;
        bus.frame_clk = 1'b1;
        repeat (1000) @(negedge clk);
        bus.frame_clk = 1'b0;
        repeat (2) @(negedge clk);
        check_pos("held strobe", 102, 384, 0, 0);

        mon_en = 1'b0;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
